// File: rtl/credit_counter_pkg.sv
// Shared types and constants for the credit/reward stage.
// Imported by credit_counter and bcd_digit_updown.
package credit_counter_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } disp_state_e;

    localparam bcd_t       BCD_MAX_DIGIT = 4'd9;
    localparam logic [7:0] DISCARD_MAX   = 8'd255;

endpackage

// File: rtl/bcd_digit_updown.sv
// One BCD digit stepping up or down by one, with carry/borrow chaining.
// Purely combinational; the caller registers the result.
module bcd_digit_updown
    import credit_counter_pkg::*;
(
    input  bcd_t digit_i,
    input  logic inc_i,
    input  logic dec_i,
    input  logic cin_i,
    input  logic bin_i,
    output bcd_t digit_o,
    output logic cout_o,
    output logic bout_o
);

    logic up;
    logic dn;

    assign up = inc_i | cin_i;
    assign dn = dec_i | bin_i;

    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        bout_o  = 1'b0;
        if (up && !dn) begin
            if (digit_i == BCD_MAX_DIGIT) begin
                digit_o = '0;
                cout_o  = 1'b1;
            end else begin
                digit_o = digit_i + 4'd1;
            end
        end else if (dn && !up) begin
            if (digit_i == '0) begin
                digit_o = BCD_MAX_DIGIT;
                bout_o  = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/credit_counter.sv
// BCD credit balance, saturating discard tally and reward-dispense
// handshake driven by edge-detected strobes from the sorting FSM.
module credit_counter
    import credit_counter_pkg::*;
#(
    parameter int REWARD_THRESH    = 10,
    parameter int DISPENSE_TIMEOUT = 255,
    parameter int TOUT_W           = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       addg,
    input  logic       dec,
    input  logic       lixo,
    input  logic       back,
    input  logic       disp_ack,
    output logic [3:0] credit_tens,
    output logic [3:0] credit_ones,
    output logic [7:0] discard_cnt,
    output logic       disp_req,
    output logic       disp_fault,
    output logic       cycle_done
);

    localparam bcd_t TH_TENS = bcd_t'(REWARD_THRESH / 10);
    localparam bcd_t TH_ONES = bcd_t'(REWARD_THRESH % 10);
    localparam logic [TOUT_W-1:0] TOUT_MAX = TOUT_W'(DISPENSE_TIMEOUT);

    // Strobe order: {back, lixo, dec, addg}
    logic [3:0] in_q, in_p_q, ev;
    logic ev_add, ev_dec, ev_lixo, ev_back;

    bcd_t tens_q, ones_q, tens_d, ones_d;
    bcd_t base_tens, base_ones;
    logic [7:0] disc_q, disc_d;
    logic fault_q, done_q, fault_set;
    logic bal_ge, grant, sub_borrow;
    logic at_max, at_min, step_up, step_dn;
    logic ones_cout, ones_bout, tens_cout, tens_bout;

    disp_state_e state_q, state_d;
    logic [TOUT_W-1:0] tout_q, tout_d, tout_inc;

    assign ev      = in_q & ~in_p_q;
    assign ev_add  = ev[0];
    assign ev_dec  = ev[1];
    assign ev_lixo = ev[2];
    assign ev_back = ev[3];

    assign bal_ge   = {tens_q, ones_q} >= {TH_TENS, TH_ONES};
    assign grant    = (state_q == IDLE) && bal_ge;
    assign tout_inc = tout_q + 1'b1;

    // Grant subtraction first, then the +/-1 step on the reduced value
    always_comb begin
        base_tens  = tens_q;
        base_ones  = ones_q;
        sub_borrow = 1'b0;
        if (grant) begin
            if (ones_q >= TH_ONES) begin
                base_ones = ones_q - TH_ONES;
            end else begin
                base_ones  = ones_q + 4'd10 - TH_ONES;
                sub_borrow = 1'b1;
            end
            base_tens = tens_q - TH_TENS - {3'b000, sub_borrow};
        end
    end

    assign at_max  = (base_tens == BCD_MAX_DIGIT) && (base_ones == BCD_MAX_DIGIT);
    assign at_min  = (base_tens == '0) && (base_ones == '0);
    assign step_up = ev_add & ~ev_dec & ~at_max;
    assign step_dn = ev_dec & ~ev_add & ~at_min;

    bcd_digit_updown u_ones (
        .digit_i (base_ones),
        .inc_i   (step_up),
        .dec_i   (step_dn),
        .cin_i   (1'b0),
        .bin_i   (1'b0),
        .digit_o (ones_d),
        .cout_o  (ones_cout),
        .bout_o  (ones_bout)
    );

    bcd_digit_updown u_tens (
        .digit_i (base_tens),
        .inc_i   (1'b0),
        .dec_i   (1'b0),
        .cin_i   (ones_cout),
        .bin_i   (ones_bout),
        .digit_o (tens_d),
        .cout_o  (tens_cout),
        .bout_o  (tens_bout)
    );

    assign disc_d = (ev_lixo && disc_q != DISCARD_MAX) ? disc_q + 8'd1 : disc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q    <= '0;
            in_p_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            disc_q  <= '0;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            in_q    <= {back, lixo, dec, addg};
            in_p_q  <= in_q;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            disc_q  <= disc_d;
            fault_q <= fault_q | fault_set;
            done_q  <= ev_back;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tout_q  <= '0;
        end else begin
            state_q <= state_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tout_d    = tout_q;
        fault_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bal_ge) begin
                    state_d = REQ;
                    tout_d  = '0;
                end
            end
            REQ: begin
                if (disp_ack) begin
                    state_d = HOLD;
                end else if (tout_inc == TOUT_MAX) begin
                    state_d   = IDLE;
                    fault_set = 1'b1;
                end else begin
                    tout_d = tout_inc;
                end
            end
            HOLD: begin
                if (!disp_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        disp_req = (state_q == REQ);
    end

    assign credit_tens = tens_q;
    assign credit_ones = ones_q;
    assign discard_cnt = disc_q;
    assign disp_fault  = fault_q;
    assign cycle_done  = done_q;

endmodule

// File: tb/tb_credit_counter.sv
// Randomized and directed checks of credit_counter against an
// integer-arithmetic reference model.
module tb_credit_counter;

    localparam int THRESH = 10;
    localparam int TMO    = 255;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       addg, dec, lixo, back, disp_ack;
    logic [3:0] credit_tens, credit_ones;
    logic [7:0] discard_cnt;
    logic       disp_req, disp_fault, cycle_done;

    always #5 clk = ~clk;

    credit_counter #(
        .REWARD_THRESH    (THRESH),
        .DISPENSE_TIMEOUT (TMO),
        .TOUT_W           (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .addg        (addg),
        .dec         (dec),
        .lixo        (lixo),
        .back        (back),
        .disp_ack    (disp_ack),
        .credit_tens (credit_tens),
        .credit_ones (credit_ones),
        .discard_cnt (discard_cnt),
        .disp_req    (disp_req),
        .disp_fault  (disp_fault),
        .cycle_done  (cycle_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers and flags
    int       m_bal, m_disc, m_age;
    bit       m_req, m_hold, m_fault, m_done;
    bit [3:0] m_s, m_p;
    int       dut_grants, req_hi;
    bit       last_req;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic cmp_all();
        chk("tens", credit_tens, m_bal / 10);
        chk("ones", credit_ones, m_bal % 10);
        chk("discard", discard_cnt, m_disc);
        chk("disp_req", disp_req, m_req);
        chk("fault", disp_fault, m_fault);
        chk("cycle_done", cycle_done, m_done);
    endtask

    task automatic step(bit a, bit d, bit l, bit b, bit k);
        bit [3:0] ev;
        bit       grant;
        addg = a; dec = d; lixo = l; back = b; disp_ack = k;
        @(posedge clk);
        #1;
        ev    = m_s & ~m_p;
        grant = !m_req && !m_hold && (m_bal >= THRESH);
        if (grant) m_bal = m_bal - THRESH;
        if (ev[0] && !ev[1] && m_bal < 99) m_bal++;
        else if (ev[1] && !ev[0] && m_bal > 0) m_bal--;
        if (ev[2] && m_disc < 255) m_disc++;
        m_done = ev[3];
        if (grant) begin
            m_req = 1; m_age = 0;
        end else if (m_req) begin
            if (k) begin
                m_req = 0; m_hold = 1;
            end else begin
                m_age++;
                if (m_age == TMO) begin
                    m_req = 0; m_fault = 1;
                end
            end
        end else if (m_hold && !k) begin
            m_hold = 0;
        end
        m_p = m_s;
        m_s = {b, l, d, a};
        cmp_all();
        if (disp_req === 1'b1) req_hi++;
        if (disp_req === 1'b1 && !last_req) dut_grants++;
        last_req = (disp_req === 1'b1);
    endtask

    task automatic pulse(bit a, bit d, bit l, bit b);
        step(a, d, l, b, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset mid-cycle and checks outputs clear before any edge
    task automatic do_reset();
        reset_n = 1'b0;
        addg = 0; dec = 0; lixo = 0; back = 0; disp_ack = 0;
        #1;
        m_bal = 0; m_disc = 0; m_age = 0;
        m_req = 0; m_hold = 0; m_fault = 0; m_done = 0;
        m_s = '0; m_p = '0;
        last_req = 0;
        cmp_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bit a, d, l, b;
        int g0;
        reset_n = 1'b1;
        addg = 0; dec = 0; lixo = 0; back = 0; disp_ack = 0;
        #2;
        do_reset();

        // Three addg events, one held for several cycles
        pulse(1, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        pulse(1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("s1_tens", credit_tens, 0);
        chk("s1_ones", credit_ones, 3);
        chk("s1_disc", discard_cnt, 0);
        chk("s1_req", disp_req, 0);

        // 09 -> 10 -> grant, then a 4-cycle ack
        do_reset();
        repeat (9) pulse(1, 0, 0, 0);
        chk("s2_nine", credit_ones, 9);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("s2_ten_t", credit_tens, 1);
        chk("s2_ten_o", credit_ones, 0);
        chk("s2_ten_req", disp_req, 0);
        g0 = dut_grants;
        step(0, 0, 0, 0, 0);
        chk("s2_grant_req", disp_req, 1);
        chk("s2_grant_bal", {credit_tens, credit_ones}, 0);
        step(0, 0, 0, 0, 1);
        chk("s2_ack_drop", disp_req, 0);
        repeat (3) step(0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0);
        chk("s2_one_grant", dut_grants - g0, 1);

        // Underflow clamp and simultaneous add/dec
        do_reset();
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        chk("s3_zero", {credit_tens, credit_ones}, 0);
        repeat (5) pulse(1, 0, 0, 0);
        pulse(1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("s3_five", credit_ones, 5);

        // Discard saturation, credit untouched
        repeat (300) pulse(0, 0, 1, 0);
        chk("s4_disc_sat", discard_cnt, 255);
        chk("s4_credit", credit_ones, 5);

        // Timeout with no ack: credit stays reduced, fault sticks
        do_reset();
        req_hi = 0;
        repeat (12) pulse(1, 0, 0, 0);
        repeat (300) step(0, 0, 0, 0, 0);
        chk("s5_req_cycles", req_hi, TMO);
        chk("s5_fault", disp_fault, 1);
        chk("s5_req_low", disp_req, 0);
        chk("s5_bal", {credit_tens, credit_ones}, 8'h02);

        // Credit saturates at 99 while a grant is pending
        do_reset();
        repeat (10) pulse(1, 0, 0, 0);
        repeat (110) pulse(1, 0, 0, 0);
        chk("s5b_sat", {credit_tens, credit_ones}, 8'h99);
        chk("s5b_req", disp_req, 1);

        // Random strobe levels and acks
        do_reset();
        a = 0; d = 0; l = 0; b = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 2) == 0) a = ~a;
            if ($urandom_range(0, 3) == 0) d = ~d;
            if ($urandom_range(0, 2) == 0) l = ~l;
            if ($urandom_range(0, 3) == 0) b = ~b;
            step(a, d, l, b, $urandom_range(0, 3) == 0);
        end

        // Async reset while a request is outstanding
        do_reset();
        repeat (3) pulse(0, 0, 1, 0);
        repeat (10) pulse(1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("s6_pre_req", disp_req, 1);
        chk("s6_pre_disc", discard_cnt, 3);
        do_reset();
        chk("s6_req", disp_req, 0);
        chk("s6_disc", discard_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/credit_counter.md
Name: credit_counter

Overview:
- Stage directly downstream of the sorting FSM; consumes its `addg` (accepted item), `dec` (deposit detected), `lixo` (discarded item) and `back` strobes.
- Keeps a 2-digit BCD credit balance and an 8-bit saturating discard tally.
- Drives a reward-dispense handshake whenever the balance reaches a threshold.
- Outputs feed the panel display and the dispenser actuator.

Parameters:
- REWARD_THRESH, 10, BCD-encodable credit value (1..99) that triggers one reward; subtracted on grant.
- DISPENSE_TIMEOUT, 255, max cycles to wait for `disp_ack` before aborting a dispense.
- TOUT_W, 8, width of the timeout counter; must hold DISPENSE_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- addg  in  1  accepted-item strobe from sorting FSM; level, may last >1 cycle
- dec  in  1  deposit strobe from sorting FSM; level
- lixo  in  1  discarded-item strobe from sorting FSM; level
- back  in  1  FSM return-to-idle indication; level
- disp_ack  in  1  dispenser acknowledge
- credit_tens  out  4  BCD tens digit of balance
- credit_ones  out  4  BCD ones digit of balance
- discard_cnt  out  8  saturating count of discarded items
- disp_req  out  1  reward request to dispenser, held until ack/timeout
- disp_fault  out  1  sticky: a dispense timed out
- cycle_done  out  1  one-cycle pulse per completed FSM transaction (rising edge of `back`)

Behaviour:
- Reset (async assert, sync-released use): all outputs 0, state IDLE, edge registers 0.
- Input conditioning:
  - Every strobe passes through one register stage.
  - Rising-edge detect against the previous registered value.
  - Each edge event counts exactly once, however long the level is held.
  - Latency from input rise to register update: 2 clk edges.
- Credit (BCD 00..99):
  - addg edge: +1, with ones 9 -> 0 carrying into tens.
  - 99 + 1 saturates at 99; no wrap.
  - dec edge: -1, with ones 0 -> 9 borrowing from tens; 00 - 1 stays 00.
  - addg and dec edges in the same cycle: no change.
- Discard:
  - lixo edge: discard_cnt +1.
  - Saturates at 255.
  - lixo coincident with addg: both act independently.
- cycle_done: 1-cycle pulse on each back rising edge (registered).
- Dispense FSM, states IDLE, REQ, HOLD:
  - IDLE -> REQ when balance >= REWARD_THRESH. On this transition: balance -= REWARD_THRESH (BCD subtract), disp_req = 1, timeout counter cleared.
  - REQ:
    - disp_req held at 1; timeout counter increments each cycle.
    - disp_ack = 1 -> HOLD, disp_req = 0.
    - Timeout counter == DISPENSE_TIMEOUT -> IDLE, disp_req = 0, disp_fault = 1.
    - On timeout the credit is NOT refunded.
  - HOLD: waits for disp_ack = 0, then -> IDLE. This prevents one long ack counting twice.
  - Credit updates from addg/dec continue in all states. If addg lands in the same cycle as the grant subtraction, the net result is applied (balance - THRESH + 1).
  - Balance still >= THRESH on return to IDLE: next grant issued 1 cycle later.
- disp_fault clears only on reset.
- Reset asserted mid-dispense: disp_req drops immediately (async); pending credit is lost.

Decomposition:
- Shared package:
  - BCD digit type (4 bits).
  - Dispense state enum {IDLE, REQ, HOLD}.
  - Constants BCD_MAX_DIGIT = 9 and DISCARD_MAX = 255.
- Sub-module `bcd_digit_updown`:
  - One BCD digit with inc/dec inputs, carry-in/borrow-in, and carry-out/borrow-out.
  - Two instances chained ones -> tens.
  - Saturation applied at the top level.
- Edge detectors and the FSM stay in the top module.

Test Plan:
- Reset then 3 addg pulses (one held 5 cycles) -> credit 03, discard_cnt 0, no disp_req.
- Start at 09, one addg pulse -> credit 10 for one cycle. Next cycle: disp_req = 1, credit 00. disp_ack high 4 cycles -> disp_req drops the cycle after ack; HOLD until ack low; exactly one grant.
- Start at 00, 2 dec pulses -> stays 00. Then addg and dec edges in the same cycle at 05 -> stays 05.
- 300 lixo pulses -> discard_cnt saturates at 255. Credit unaffected.
- Grant issued, disp_ack never asserted -> after 255 cycles in REQ: disp_req = 0, disp_fault = 1, credit remains reduced by 10.
- reset_n pulsed low while disp_req = 1 -> disp_req, credit and discard_cnt all 0 within the same cycle, before the next clk edge.
